// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared definitions for the SPI transfer sequencer: register offsets, SPSR bits,
// sequencer state encoding and the port-bus operation codes.
package spi_xfer_sequencer_pkg;

    localparam logic [7:0] OFS_SPCR = 8'd0;
    localparam logic [7:0] OFS_SPSR = 8'd1;
    localparam logic [7:0] OFS_SPDR = 8'd2;
    localparam logic [7:0] OFS_SPER = 8'd3;
    localparam logic [7:0] OFS_NCSO = 8'd4;

    localparam int SPSR_SPIF = 7;
    localparam int SPSR_WCOL = 6;

    // Writing only the SPIF bit clears it without touching WCOL.
    localparam logic [7:0] SPSR_CLR_SPIF = 8'h80;
    localparam logic [7:0] NCS_ASSERT    = 8'h00;
    localparam logic [7:0] NCS_RELEASE   = 8'h01;

    typedef enum logic [3:0] {
        ST_INIT_SPCR,
        ST_INIT_SPER,
        ST_IDLE,
        ST_CS_LOW,
        ST_WR_DATA,
        ST_POLL_A,
        ST_POLL_B,
        ST_CLR,
        ST_RD_A,
        ST_RD_B,
        ST_RSP,
        ST_CS_HIGH
    } seq_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_WR,
        BUS_RD_A,
        BUS_RD_B
    } bus_op_e;

endpackage

// File: rtl/spi_xfer_sequencer_port_bus_driver.sv
// Port-bus driver: single-cycle writes and two-phase reads (strobe, then hold);
// port_id and out_port keep their last driven values while the bus is idle.
module spi_xfer_sequencer_port_bus_driver
    import spi_xfer_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  bus_op_e    op,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port,
    output logic       done,
    output logic [7:0] rd_data
);

    logic [7:0] port_id_q;
    logic [7:0] out_port_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            port_id_q  <= 8'h00;
            out_port_q <= 8'h00;
        end else begin
            if (op != BUS_IDLE) port_id_q  <= addr;
            if (op == BUS_WR)   out_port_q <= wdata;
        end
    end

    assign port_id      = (op == BUS_IDLE) ? port_id_q : addr;
    assign out_port     = (op == BUS_WR) ? wdata : out_port_q;
    assign write_strobe = (op == BUS_WR);
    assign read_strobe  = (op == BUS_RD_A);
    assign done         = (op == BUS_WR) || (op == BUS_RD_B);
    // The register block's data_out lags port_id by a cycle, so in_port is
    // meaningful in the second read phase; the caller samples it with done.
    assign rd_data      = in_port;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// SPI transfer sequencer: initialises the SPI register block, then runs one
// SPDR exchange per client request. Optional macro: SPI_SEQ_TIMEOUT_EN (poll timeout).
module spi_xfer_sequencer
    import spi_xfer_sequencer_pkg::*;
#(
    parameter logic [7:0]        BASE_ADDRESS = 8'h00,
    parameter logic [7:0]        SPCR_INIT    = 8'h50,
    parameter logic [7:0]        SPER_INIT    = 8'h00,
    parameter int                POLL_W       = 16,
    parameter logic [POLL_W-1:0] POLL_LIMIT   = 16'd1000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_data,
    input  logic       req_last,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port,
    output logic       cs_active
);

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    seq_state_e        state_q, state_d;
    bus_op_e           bus_op;
    logic [7:0]        bus_ofs, bus_wdata, bus_rd_data;
    logic              bus_done;
    logic [7:0]        tx_q, rx_q;
    logic              last_q, cs_q, err_q;
    logic [POLL_W-1:0] poll_q, poll_inc;
    logic              accept, spif_seen, timeout;

    assign poll_inc  = (poll_q == '1) ? poll_q : poll_q + 1'b1;
    assign spif_seen = bus_done && bus_rd_data[SPSR_SPIF];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT_SPCR;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            last_q  <= 1'b0;
            cs_q    <= 1'b0;
            err_q   <= 1'b0;
            poll_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tx_q   <= req_data;
                last_q <= req_last;
                err_q  <= 1'b0;
            end
            if (state_q == ST_CS_LOW)  cs_q <= 1'b1;
            if (state_q == ST_CS_HIGH) cs_q <= 1'b0;
            if (state_q == ST_WR_DATA) poll_q <= '0;
            if (state_q == ST_POLL_B && !spif_seen) poll_q <= poll_inc;
            if (state_q == ST_RD_B && bus_done) rx_q <= bus_rd_data;
            if (timeout) begin
                err_q <= 1'b1;
                rx_q  <= 8'hFF;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_op    = BUS_IDLE;
        bus_ofs   = OFS_SPCR;
        bus_wdata = 8'h00;
        accept    = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            ST_INIT_SPCR: begin
                bus_op = BUS_WR; bus_ofs = OFS_SPCR; bus_wdata = SPCR_INIT;
                state_d = ST_INIT_SPER;
            end
            ST_INIT_SPER: begin
                bus_op = BUS_WR; bus_ofs = OFS_SPER; bus_wdata = SPER_INIT;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = cs_q ? ST_WR_DATA : ST_CS_LOW;
                end
            end
            ST_CS_LOW: begin
                bus_op = BUS_WR; bus_ofs = OFS_NCSO; bus_wdata = NCS_ASSERT;
                state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                bus_op = BUS_WR; bus_ofs = OFS_SPDR; bus_wdata = tx_q;
                state_d = ST_POLL_A;
            end
            ST_POLL_A: begin
                bus_op = BUS_RD_A; bus_ofs = OFS_SPSR;
                state_d = ST_POLL_B;
            end
            ST_POLL_B: begin
                bus_op = BUS_RD_B; bus_ofs = OFS_SPSR;
                if (spif_seen) begin
                    state_d = ST_CLR;
                end else if (TIMEOUT_EN && poll_inc >= POLL_LIMIT) begin
                    timeout = 1'b1;
                    state_d = ST_RSP;
                end else begin
                    state_d = ST_POLL_A;
                end
            end
            ST_CLR: begin
                bus_op = BUS_WR; bus_ofs = OFS_SPSR; bus_wdata = SPSR_CLR_SPIF;
                state_d = ST_RD_A;
            end
            ST_RD_A: begin
                bus_op = BUS_RD_A; bus_ofs = OFS_SPDR;
                state_d = ST_RD_B;
            end
            ST_RD_B: begin
                bus_op = BUS_RD_B; bus_ofs = OFS_SPDR;
                state_d = ST_RSP;
            end
            ST_RSP: begin
                // A timed-out byte always releases nCS so the slave resynchronises.
                if (rsp_ready) state_d = (last_q || err_q) ? ST_CS_HIGH : ST_IDLE;
            end
            ST_CS_HIGH: begin
                bus_op = BUS_WR; bus_ofs = OFS_NCSO; bus_wdata = NCS_RELEASE;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT_SPCR;
        endcase
        if (reset) bus_op = BUS_IDLE;
    end

    spi_xfer_sequencer_port_bus_driver u_bus (
        .clk          (clk),
        .reset        (reset),
        .op           (bus_op),
        .addr         (BASE_ADDRESS + bus_ofs),
        .wdata        (bus_wdata),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .in_port      (in_port),
        .done         (bus_done),
        .rd_data      (bus_rd_data)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_data  = rx_q;
    assign rsp_err   = err_q;
    assign cs_active = cs_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer: register-block model on the port bus, expected
// bus-transaction and response queues built per byte, one monitor comparing every cycle.
module tb_spi_xfer_sequencer;

    localparam int POLL_LIMIT_TB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, req_last = 1'b0, rsp_ready = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, rsp_valid, rsp_err, write_strobe, read_strobe, cs_active;
    logic [7:0] rsp_data, port_id, out_port;
    logic [7:0] in_port = 8'h00;

    typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] data; } bus_t;
    bus_t       exp_q[$];
    logic [8:0] exp_rsp[$];

    int checks = 0, errors = 0;
    int spif_after = 0, spsr_reads = 0;
    logic [7:0] spdr_rx = 8'h00;
    int n_spsr_rd = 0, n_ncs_low = 0, n_ncs_high = 0;
    bit cs_model = 1'b0;
    int lat_last = 0;
    bit mon_rd_b = 1'b0;
    logic [7:0] mon_rd_addr = 8'h00;
    bus_t mon_e;
    logic [8:0] mon_r;
    int c_lo, c_hi, c_rd;

    spi_xfer_sequencer #(.POLL_LIMIT(16'd4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe),
        .read_strobe(read_strobe), .in_port(in_port), .cs_active(cs_active)
    );

    always #5 clk = ~clk;

    // Register block model: data_out registered one cycle after the read strobe.
    always @(posedge clk) begin
        if (write_strobe && port_id == 8'h02) spsr_reads <= 0;
        if (read_strobe) begin
            if (port_id == 8'h01) begin
                spsr_reads <= spsr_reads + 1;
                in_port <= (spif_after != 0 && spsr_reads + 1 >= spif_after) ? 8'h80 : 8'h7F;
            end else if (port_id == 8'h02) begin
                in_port <= spdr_rx;
            end else begin
                in_port <= 8'h00;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic abort(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", name);
        finish_run();
    endtask

    function automatic void exp_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
    endfunction

    function automatic void exp_rd(input logic [7:0] a);
        exp_q.push_back({1'b0, a, 8'h00});
    endfunction

    // Monitor: every bus op against the expected queue, read phase B hold, responses.
    initial forever begin
        @(negedge clk);
        chk("strobe_excl", {31'd0, write_strobe & read_strobe}, 32'd0);
        if (mon_rd_b) begin
            chk("rd_cycle_b", {22'd0, read_strobe, write_strobe, port_id}, {24'd0, mon_rd_addr});
            mon_rd_b = 1'b0;
        end
        if (write_strobe || read_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected wr=%0b port_id=%h out_port=%h", write_strobe, port_id, out_port);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bus_op", {write_strobe, port_id, write_strobe ? out_port : 8'h00}, mon_e);
            end
            if (read_strobe) begin
                mon_rd_b = 1'b1;
                mon_rd_addr = port_id;
                if (port_id == 8'h01) n_spsr_rd++;
            end
            if (write_strobe && port_id == 8'h04) begin
                if (out_port == 8'h00) n_ncs_low++;
                else n_ncs_high++;
            end
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected data=%h", rsp_data);
            end else begin
                mon_r = exp_rsp.pop_front();
                chk("rsp", {rsp_err, rsp_data}, mon_r);
            end
        end
    end

    task automatic xfer(input logic [7:0] tx, input bit last, input int spif_n,
                        input logic [7:0] rx, input int hold, input bit tmo);
        int n, lat, exp_lat, waited;
        bit was_cs;
        was_cs = cs_model;
        n = tmo ? POLL_LIMIT_TB : spif_n;
        spif_after = tmo ? 0 : spif_n;
        spdr_rx = rx;
        if (!was_cs) exp_wr(8'h04, 8'h00);
        exp_wr(8'h02, tx);
        repeat (n) exp_rd(8'h01);
        if (!tmo) begin
            exp_wr(8'h01, 8'h80);
            exp_rd(8'h02);
        end
        if (last || tmo) exp_wr(8'h04, 8'h01);
        exp_rsp.push_back(tmo ? 9'h1FF : {1'b0, rx});
        // nCS write, SPDR write, n two-cycle polls, then RSP (or CLR + 2-cycle read + RSP).
        exp_lat = (was_cs ? 0 : 1) + 1 + 2 * n + (tmo ? 1 : 4);
        @(posedge clk); #1;
        req_valid = 1'b1; req_data = tx; req_last = last;
        waited = 0;
        do begin @(negedge clk); waited++; end while (!req_ready && waited < 50);
        if (!req_ready) abort("req_ready_wait");
        @(posedge clk); #1;
        req_valid = 1'b0; req_data = 8'h00; req_last = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("req_ready_drop", {31'd0, req_ready}, 32'd0);
        end while (!rsp_valid && lat < 1000);
        if (!rsp_valid) abort("rsp_wait");
        lat_last = lat;
        chk("latency", lat, exp_lat);
        chk("cs_in_rsp", {31'd0, cs_active}, 32'd1);
        repeat (hold) begin
            @(negedge clk);
            chk("hold", {rsp_valid, req_ready, read_strobe, write_strobe, rsp_data},
                {4'b1000, tmo ? 8'hFF : rx});
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        if (last || tmo) begin
            @(negedge clk);
            @(negedge clk);
            chk("cs_release", {30'd0, cs_active, req_ready}, 32'd1);
        end else begin
            @(negedge clk);
            chk("cs_kept", {30'd0, cs_active, req_ready}, 32'd3);
        end
        cs_model = !(last || tmo);
    endtask

    task automatic release_and_init();
        exp_wr(8'h00, 8'h50);
        exp_wr(8'h03, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("init_spcr", {15'd0, write_strobe, port_id, out_port}, 32'h0001_0050);
        @(negedge clk);
        chk("init_sper", {15'd0, write_strobe, port_id, out_port}, 32'h0001_0300);
        @(negedge clk);
        chk("idle_ready", {30'd0, req_ready, write_strobe}, 32'd2);
    endtask

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog time limit");
        finish_run();
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {26'd0, write_strobe, read_strobe, req_ready, rsp_valid, cs_active, rsp_err}, 32'd0);
        chk("reset_bus", {8'd0, port_id, out_port, rsp_data}, 32'd0);
        release_and_init();

        c_rd = n_spsr_rd;
        xfer(8'hA5, 1'b1, 3, 8'h3C, 0, 1'b0);
        chk("a5_spsr_reads", n_spsr_rd - c_rd, 3);

        c_lo = n_ncs_low; c_hi = n_ncs_high;
        xfer(8'h0B, 1'b0, 1, 8'h11, 10, 1'b0);
        xfer(8'h00, 1'b1, 2, 8'h22, 0, 1'b0);
        chk("two_byte_ncs_low", n_ncs_low - c_lo, 1);
        chk("two_byte_ncs_high", n_ncs_high - c_hi, 1);

        xfer(8'h5A, 1'b0, 1, 8'h66, 0, 1'b0);
        chk("lat_with_cs", lat_last, 8);
        xfer(8'hC3, 1'b1, 1, 8'h99, 0, 1'b0);
        chk("lat_min", lat_last, 7);

`ifdef SPI_SEQ_TIMEOUT_EN
        c_rd = n_spsr_rd; c_hi = n_ncs_high;
        xfer(8'h77, 1'b0, 0, 8'h00, 0, 1'b1);
        chk("tmo_spsr_reads", n_spsr_rd - c_rd, 4);
        chk("tmo_forced_cs_high", n_ncs_high - c_hi, 1);
        chk("tmo_err_sticky", {31'd0, rsp_err}, 32'd1);
        xfer(8'h12, 1'b1, 2, 8'h34, 0, 1'b0);
        chk("err_cleared", {31'd0, rsp_err}, 32'd0);
`endif

        // Reset while the sequencer is in the second phase of an SPSR poll.
        spif_after = 0;
        exp_wr(8'h04, 8'h00);
        exp_wr(8'h02, 8'h99);
        exp_rd(8'h01);
        @(posedge clk); #1;
        req_valid = 1'b1; req_data = 8'h99; req_last = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_last = 1'b0; req_data = 8'h00;
        c_rd = 0;
        do begin @(negedge clk); c_rd++; end while (!read_strobe && c_rd < 20);
        if (!read_strobe) abort("poll_wait");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_ctl", {27'd0, write_strobe, read_strobe, req_ready, rsp_valid, cs_active}, 32'd0);
        chk("abort_queue", exp_q.size(), 0);
        exp_rsp.delete();
        cs_model = 1'b0;
        release_and_init();
        xfer(8'h3C, 1'b1, 1, 8'hC3, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("exp_bus_drained", exp_q.size(), 0);
        chk("exp_rsp_drained", exp_rsp.size(), 0);
        finish_run();
    end

endmodule
